// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - single-entry instruction fetch unit with redirect/drop handling
//
// Purpose: issues one instruction-bus request at a time, buffers the returned
// word for the decode stage, and cancels in-flight requests on redirects.
// Optional build macro: IFETCH_MISALIGN_CHECK_EN enables misaligned-fetch
// detection (no bus request for an address with [1:0] != 0; a fault entry is
// presented instead).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ireq_valid/addr     instruction-bus request (held until iresp_data_ok)
//   iresp_data_ok/data  one-cycle response pulse with instruction word
//   redirect_valid/pc   control-flow redirect from a later stage
//   stall               downstream cannot accept the held instruction
//   instr_valid, raw_instr, pc, misalign   buffered entry for decode
module ifetch_unit #(
    parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] raw_instr,
    output logic [63:0] pc,
    output logic        misalign
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t      state_q, state_n;
    logic [63:0] req_addr_q, req_addr_n;
    logic [63:0] pend_q, pend_n;

    // Buffer update controls
    logic        buf_load;
    logic        buf_clear;
    logic [31:0] buf_instr;
    logic [63:0] buf_pc;

    // New request target (redirect, pending target or sequential pc+4)
    logic        take_target;
    logic [63:0] target;

    logic        data_ok;

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        misalign_q;
    logic        buf_mis;
`endif

    // The bus is reset with us, so a response can only belong to a live request.
    assign ireq_valid = !reset && (state_q != S_HOLD);
    assign ireq_addr  = req_addr_q;
    assign data_ok    = iresp_data_ok && ireq_valid;

    always_comb begin
        state_n     = state_q;
        req_addr_n  = req_addr_q;
        pend_n      = pend_q;
        buf_load    = 1'b0;
        buf_clear   = 1'b0;
        buf_instr   = iresp_data;
        buf_pc      = req_addr_q;
        take_target = 1'b0;
        target      = req_addr_q;
`ifdef IFETCH_MISALIGN_CHECK_EN
        buf_mis     = 1'b0;
`endif

        case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    if (data_ok) begin
                        // Response arrives with the redirect: drop it, go straight on.
                        take_target = 1'b1;
                        target      = redirect_pc;
                    end else begin
                        // Request still in flight: wait it out before re-issuing.
                        pend_n  = redirect_pc;
                        state_n = S_DROP;
                    end
                end else if (data_ok) begin
                    buf_load = 1'b1;
                    state_n  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    buf_clear   = 1'b1;
                    take_target = 1'b1;
                    target      = redirect_pc;
                end else if (!stall) begin
                    buf_clear   = 1'b1;
                    take_target = 1'b1;
                    target      = pc + 64'd4;
                end
            end
            S_DROP: begin
                if (data_ok) begin
                    // Same-cycle redirect is the newest target.
                    take_target = 1'b1;
                    target      = redirect_valid ? redirect_pc : pend_q;
                end else if (redirect_valid) begin
                    pend_n = redirect_pc;
                end
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase

        if (take_target) begin
            req_addr_n = target;
            state_n    = S_FETCH;
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (target[1:0] != 2'b00) begin
                // Never issue a misaligned address; present a fault entry instead.
                state_n   = S_HOLD;
                buf_clear = 1'b0;
                buf_load  = 1'b1;
                buf_instr = 32'd0;
                buf_pc    = target;
                buf_mis   = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            req_addr_q  <= PCINIT;
            pend_q      <= 64'd0;
            instr_valid <= 1'b0;
            raw_instr   <= 32'd0;
            pc          <= 64'd0;
        end else begin
            state_q    <= state_n;
            req_addr_q <= req_addr_n;
            pend_q     <= pend_n;
            if (buf_load) begin
                instr_valid <= 1'b1;
                raw_instr   <= buf_instr;
                pc          <= buf_pc;
            end else if (buf_clear) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else if (buf_load) begin
            misalign_q <= buf_mis;
        end else if (buf_clear) begin
            misalign_q <= 1'b0;
        end
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] raw_instr;
    logic [63:0] pc;
    logic        misalign;

    int tests  = 0;
    int failed = 0;

    ifetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .raw_instr      (raw_instr),
        .pc             (pc),
        .misalign       (misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        iresp_data_ok  = 1'b0;
        iresp_data     = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        stall          = 1'b0;
        step();
        step();
        chk("rst_ireq_valid", ireq_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_raw", raw_instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_misalign", misalign, 0);

        // First fetch, bus answers 3 cycles later
        reset = 1'b0;
        #1;
        chk("first_ireq_valid", ireq_valid, 1);
        chk("first_addr", ireq_addr, 64'h8000_0000);
        step();
        step();
        step();
        chk("first_addr_held", ireq_addr, 64'h8000_0000);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0013;
        #1;
        chk("first_not_yet_valid", instr_valid, 0);
        step();
        iresp_data_ok = 1'b0;
        chk("first_valid", instr_valid, 1);
        chk("first_pc", pc, 64'h8000_0000);
        chk("first_raw", raw_instr, 32'h0000_0013);
        chk("hold_no_req", ireq_valid, 0);

        // Stall for 4 cycles
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_valid", instr_valid, 1);
            chk("stall_pc", pc, 64'h8000_0000);
            chk("stall_raw", raw_instr, 32'h0000_0013);
            chk("stall_no_req", ireq_valid, 0);
        end
        stall = 1'b0;
        step();
        chk("seq_valid_drop", instr_valid, 0);
        chk("seq_req_valid", ireq_valid, 1);
        chk("seq_addr", ireq_addr, 64'h8000_0004);

        // Redirect while fetch outstanding; response 2 cycles later
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0100;
        step();
        redirect_valid = 1'b0;
        chk("drop_addr_held", ireq_addr, 64'h8000_0004);
        chk("drop_req_valid", ireq_valid, 1);
        chk("drop_no_instr", instr_valid, 0);
        step();
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hdead_beef;
        #1;
        chk("drop_addr_at_ok", ireq_addr, 64'h8000_0004);
        step();
        iresp_data_ok = 1'b0;
        chk("drop_discard", instr_valid, 0);
        chk("drop_new_addr", ireq_addr, 64'h8000_0100);

        // Redirect in HOLD with stall
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0010_0093;
        step();
        iresp_data_ok = 1'b0;
        chk("hold2_valid", instr_valid, 1);
        chk("hold2_pc", pc, 64'h8000_0100);
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        step();
        redirect_valid = 1'b0;
        chk("hold_redir_valid", instr_valid, 0);
        chk("hold_redir_req", ireq_valid, 1);
        chk("hold_redir_addr", ireq_addr, 64'h8000_0200);

        // Two redirects in DROP, last one wins
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0300;
        step();
        redirect_pc    = 64'h8000_0400;
        step();
        redirect_valid = 1'b0;
        chk("drop2_addr_held", ireq_addr, 64'h8000_0200);
        iresp_data_ok = 1'b1;
        step();
        iresp_data_ok = 1'b0;
        chk("drop2_addr", ireq_addr, 64'h8000_0400);
        chk("drop2_no_instr", instr_valid, 0);
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0013;
        step();
        iresp_data_ok = 1'b0;
        chk("drop2_fetch_pc", pc, 64'h8000_0400);

        // Spurious data_ok in HOLD is ignored
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h1234_5678;
        step();
        iresp_data_ok = 1'b0;
        chk("spurious_raw", raw_instr, 32'h0000_0013);
        chk("spurious_valid", instr_valid, 1);

        // pc+4 wraps at 64 bits
        redirect_valid = 1'b1;
        redirect_pc    = 64'hffff_ffff_ffff_fffc;
        step();
        redirect_valid = 1'b0;
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'h0000_0067;
        step();
        iresp_data_ok = 1'b0;
        chk("wrap_pc", pc, 64'hffff_ffff_ffff_fffc);
        stall = 1'b0;
        step();
        chk("wrap_addr", ireq_addr, 64'd0);

        // Redirect with data_ok in FETCH: data discarded
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0500;
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'hbad0_bad0;
        step();
        redirect_valid = 1'b0;
        iresp_data_ok  = 1'b0;
        chk("fetch_redir_ok_valid", instr_valid, 0);
        chk("fetch_redir_ok_addr", ireq_addr, 64'h8000_0500);

        // Misaligned redirect target
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0013;
        step();
        iresp_data_ok  = 1'b0;
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0102;
        step();
        redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk("mis_req", ireq_valid, 0);
        chk("mis_valid", instr_valid, 1);
        chk("mis_flag", misalign, 1);
        chk("mis_pc", pc, 64'h8000_0102);
        chk("mis_raw", raw_instr, 0);
`else
        chk("mis_req", ireq_valid, 1);
        chk("mis_addr", ireq_addr, 64'h8000_0102);
        chk("mis_valid", instr_valid, 0);
        chk("mis_flag", misalign, 0);
`endif

        // Reset mid-transaction
        stall = 1'b0;
        reset = 1'b1;
        step();
        chk("rst2_req", ireq_valid, 0);
        chk("rst2_valid", instr_valid, 0);
        chk("rst2_misalign", misalign, 0);
        reset = 1'b0;
        #1;
        chk("rst2_addr", ireq_addr, 64'h8000_0000);
        chk("rst2_req_after", ireq_valid, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter PCINIT, default 64'h0000_0000_8000_0000, the PC value loaded at reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ireq_valid  output  1  instruction-bus request valid.
REQ-005 ireq_addr  output  64  instruction-bus request address.
REQ-006 iresp_data_ok  input  1  one-cycle pulse: response data valid for the outstanding request.
REQ-007 iresp_data  input  32  instruction word returned with iresp_data_ok.
REQ-008 redirect_valid  input  1  control-flow redirect from a later stage.
REQ-009 redirect_pc  input  64  redirect target.
REQ-010 stall  input  1  downstream fetch/decode stage cannot accept the held instruction.
REQ-011 instr_valid  output  1  raw_instr/pc hold a valid instruction for the fetch stage.
REQ-012 raw_instr  output  32  fetched instruction word.
REQ-013 pc  output  64  address of raw_instr.
REQ-014 misalign  output  1  held entry is a misaligned-fetch fault (see Configuration).

Function
REQ-015 The block SHALL implement three states: FETCH (request outstanding), HOLD (instruction buffered), DROP (cancelled request still outstanding).
REQ-016 In FETCH and DROP, ireq_valid SHALL be 1; in HOLD it SHALL be 0.
REQ-017 ireq_addr SHALL come from a dedicated request-address register and SHALL stay constant from assertion of ireq_valid until the cycle iresp_data_ok is seen.
REQ-018 FETCH, data_ok=1, redirect=0: capture iresp_data and request address into the output buffer; go to HOLD; instr_valid=1 starting the next cycle (1-cycle latency from data_ok).
REQ-019 HOLD, stall=1, redirect=0: raw_instr, pc, instr_valid SHALL stay unchanged.
REQ-020 HOLD, stall=0, redirect=0: request address <= pc+4 (64-bit wrap-around, no carry out); go to FETCH; instr_valid=0 next cycle.
REQ-021 redirect_valid SHALL take priority over stall and over iresp_data_ok in every state.
REQ-022 Redirect in HOLD, or in FETCH in the same cycle as data_ok: discard any data; request address <= redirect_pc; go to FETCH.
REQ-023 Redirect in FETCH without data_ok: remember redirect_pc as the pending target; go to DROP; ireq_addr unchanged.
REQ-024 In DROP, a further redirect SHALL overwrite the pending target (last one wins); on data_ok, discard the data, request address <= pending target, go to FETCH.
REQ-025 Data returned in DROP SHALL never reach raw_instr; instr_valid SHALL be 0 throughout FETCH and DROP.
REQ-026 iresp_data_ok while ireq_valid=0 SHALL be ignored.

Reset
REQ-027 While reset=1: state=FETCH, request address=PCINIT, ireq_valid=0, instr_valid=0, raw_instr=0, pc=0, misalign=0.
REQ-028 First cycle after reset deasserts: ireq_valid=1, ireq_addr=PCINIT.
REQ-029 Reset mid-transaction SHALL abandon the outstanding request; the instruction bus is reset by the same reset.

Configuration
REQ-030 Macro IFETCH_MISALIGN_CHECK_EN SHALL compile in misaligned-fetch detection.
REQ-031 Defined: a next request address with [1:0]!=0 SHALL NOT be issued; the block goes directly to HOLD with instr_valid=1, raw_instr=0, pc=that address, misalign=1; the entry is then subject to stall/redirect as in REQ-019..REQ-022.
REQ-032 Undefined: misalign SHALL be tied 0 and addresses SHALL be issued unchanged regardless of low bits.

Verification
REQ-033 Reset, bus answers 3 cycles later with 32'h0000_0013 -> ireq_addr=8000_0000; instr_valid=1 next cycle with pc=8000_0000, raw_instr=0000_0013.
REQ-034 Instruction held, stall=1 for 4 cycles, then 0 -> outputs frozen 4 cycles, ireq_valid=0; next request ireq_addr=8000_0004.
REQ-035 Redirect to 8000_0100 while FETCH at 8000_0004 outstanding, response 2 cycles later -> ireq_addr stays 8000_0004 until data_ok, data discarded, next request 8000_0100, no instr_valid in between.
REQ-036 Redirect to 8000_0200 in HOLD with stall=1 -> buffer dropped next cycle, ireq_addr=8000_0200.
REQ-037 Two redirects in DROP (8000_0300 then 8000_0400) -> next issued request 8000_0400.
REQ-038 With IFETCH_MISALIGN_CHECK_EN, redirect to 8000_0102 -> no bus request, instr_valid=1, misalign=1, pc=8000_0102, raw_instr=0.
